// File: rtl/spi_pkg.sv
// Shared SPI definitions: chip-select sequencer state encoding, delay counter
// width and the transaction length qualifier.
package spi_pkg;

    typedef enum logic [2:0] {
        CS_IDLE     = 3'd0,
        CS_LEAD     = 3'd1,
        CS_ISSUE    = 3'd2,
        CS_WAIT_RX  = 3'd3,
        CS_WAIT_TX  = 3'd4,
        CS_INACTIVE = 3'd5
    } spi_cs_state_t;

    localparam int DLY_W = 8;

    // A transaction length is usable only when it is non-zero and fits one CS frame.
    function automatic logic count_ok(input logic [31:0] cnt, input logic [31:0] max_cnt);
        return (cnt != 32'd0) && (cnt <= max_cnt);
    endfunction

endpackage

// File: rtl/spi_delay_cnt.sv
// Loadable down-counter: start_i arms it with load_i and done_o is high during
// the load_i-th cycle after the start edge.
module spi_delay_cnt
    import spi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [DLY_W-1:0] load_i,
    output logic             done_o
);

    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // Next-state for the countdown.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            cnt_d  = load_i - DLY_W'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - DLY_W'(1);
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/spi_master_cs.sv
// Chip-select transaction sequencer in front of the SPI byte engine: frames a
// multi-byte transfer with CS_n and feeds the engine one byte at a time.
module spi_master_cs
    import spi_pkg::*;
#(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int CS_LEAD_CLKS     = 4,
    parameter int CS_INACTIVE_CLKS = 2,
    parameter int CNT_W            = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] i_TX_Count,
    input  logic [7:0]       i_TX_byte,
    input  logic             i_TX_En,
    output logic             o_TX_Ready,
    output logic [CNT_W-1:0] o_RX_Count,
    output logic [7:0]       o_RX_byte,
    output logic             o_RX_En,
    output logic [7:0]       o_Eng_TX_byte,
    output logic             o_Eng_TX_En,
    input  logic             i_Eng_TX_Ready,
    input  logic [7:0]       i_Eng_RX_byte,
    input  logic             i_Eng_RX_En,
    output logic             o_CS_n
);

    localparam logic [DLY_W-1:0] LEAD_LOAD  = DLY_W'(CS_LEAD_CLKS);
    localparam logic [DLY_W-1:0] INACT_LOAD = DLY_W'(CS_INACTIVE_CLKS);

    spi_cs_state_t    state_q, state_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             cs_n_q, cs_n_d;
    logic             tx_ready_q, tx_ready_d;
    logic             eng_en_q, eng_en_d;
    logic [7:0]       eng_byte_q, eng_byte_d;
    logic             rx_en_q, rx_en_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;

    logic             accept_s, latch_s, rx_fire_s, last_s;
    logic             dly_start_s, dly_done_s;
    logic [DLY_W-1:0] dly_load_s;

    assign accept_s    = (state_q == CS_IDLE) && i_TX_En
                         && count_ok(32'(i_TX_Count), 32'(MAX_BYTES_PER_CS));
    assign latch_s     = accept_s || ((state_q == CS_WAIT_TX) && i_TX_En);
    assign rx_fire_s   = (state_q == CS_WAIT_RX) && i_Eng_RX_En;
    assign last_s      = (rem_q == CNT_W'(1));
    assign dly_start_s = accept_s || (rx_fire_s && last_s);
    assign dly_load_s  = accept_s ? LEAD_LOAD : INACT_LOAD;

    spi_delay_cnt u_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (dly_start_s),
        .load_i  (dly_load_s),
        .done_o  (dly_done_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a byte is handed over directly when the engine is already ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CS_IDLE:     state_d = accept_s ? CS_LEAD : CS_IDLE;
            CS_LEAD:     if (dly_done_s) begin
                             state_d = i_Eng_TX_Ready ? CS_WAIT_RX : CS_ISSUE;
                         end else begin
                             state_d = CS_LEAD;
                         end
            CS_ISSUE:    state_d = i_Eng_TX_Ready ? CS_WAIT_RX : CS_ISSUE;
            CS_WAIT_RX:  if (rx_fire_s) begin
                             state_d = last_s ? CS_INACTIVE : CS_WAIT_TX;
                         end else begin
                             state_d = CS_WAIT_RX;
                         end
            CS_WAIT_TX:  if (i_TX_En) begin
                             state_d = i_Eng_TX_Ready ? CS_WAIT_RX : CS_ISSUE;
                         end else begin
                             state_d = CS_WAIT_TX;
                         end
            CS_INACTIVE: state_d = dly_done_s ? CS_IDLE : CS_INACTIVE;
            default:     state_d = CS_IDLE;
        endcase
    end

    // Output and datapath next values, derived from the upcoming state.
    always_comb begin
        cs_n_d     = (state_d == CS_IDLE) || (state_d == CS_INACTIVE);
        tx_ready_d = (state_d == CS_IDLE) || (state_d == CS_WAIT_TX);
        eng_en_d   = (state_d == CS_WAIT_RX) && (state_q != CS_WAIT_RX);
        tx_byte_d  = latch_s ? i_TX_byte : tx_byte_q;
        if (eng_en_d) begin
            eng_byte_d = latch_s ? i_TX_byte : tx_byte_q;
        end else begin
            eng_byte_d = eng_byte_q;
        end
        rx_en_d   = rx_fire_s;
        rx_byte_d = rx_fire_s ? i_Eng_RX_byte : rx_byte_q;
        if (accept_s) begin
            rx_cnt_d = '0;
            rem_d    = i_TX_Count;
        end else if (rx_fire_s) begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
            rem_d    = rem_q - CNT_W'(1);
        end else begin
            rx_cnt_d = rx_cnt_q;
            rem_d    = rem_q;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_n_q     <= 1'b1;
            tx_ready_q <= 1'b1;
            eng_en_q   <= 1'b0;
            eng_byte_q <= 8'h00;
            tx_byte_q  <= 8'h00;
            rx_en_q    <= 1'b0;
            rx_byte_q  <= 8'h00;
            rx_cnt_q   <= '0;
            rem_q      <= '0;
        end else begin
            cs_n_q     <= cs_n_d;
            tx_ready_q <= tx_ready_d;
            eng_en_q   <= eng_en_d;
            eng_byte_q <= eng_byte_d;
            tx_byte_q  <= tx_byte_d;
            rx_en_q    <= rx_en_d;
            rx_byte_q  <= rx_byte_d;
            rx_cnt_q   <= rx_cnt_d;
            rem_q      <= rem_d;
        end
    end

    assign o_CS_n        = cs_n_q;
    assign o_TX_Ready    = tx_ready_q;
    assign o_Eng_TX_En   = eng_en_q;
    assign o_Eng_TX_byte = eng_byte_q;
    assign o_RX_En       = rx_en_q;
    assign o_RX_byte     = rx_byte_q;
    assign o_RX_Count    = rx_cnt_q;

endmodule

// File: tb/tb_spi_master_cs.sv
// Self-checking bench for spi_master_cs: loopback engine model, transaction-level
// expectation queues and frame-timing checks.
module tb_spi_master_cs;

    localparam int MAXB  = 2;
    localparam int LEAD  = 4;
    localparam int INACT = 2;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] i_TX_Count = '0;
    logic [7:0]    i_TX_byte = 8'h00;
    logic          i_TX_En = 1'b0;
    logic          o_TX_Ready;
    logic [CW-1:0] o_RX_Count;
    logic [7:0]    o_RX_byte;
    logic          o_RX_En;
    logic [7:0]    o_Eng_TX_byte;
    logic          o_Eng_TX_En;
    logic          i_Eng_TX_Ready = 1'b1;
    logic [7:0]    i_Eng_RX_byte = 8'h00;
    logic          i_Eng_RX_En = 1'b0;
    logic          o_CS_n;

    always #5 clk = ~clk;

    spi_master_cs #(
        .MAX_BYTES_PER_CS (MAXB),
        .CS_LEAD_CLKS     (LEAD),
        .CS_INACTIVE_CLKS (INACT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_TX_Count     (i_TX_Count),
        .i_TX_byte      (i_TX_byte),
        .i_TX_En        (i_TX_En),
        .o_TX_Ready     (o_TX_Ready),
        .o_RX_Count     (o_RX_Count),
        .o_RX_byte      (o_RX_byte),
        .o_RX_En        (o_RX_En),
        .o_Eng_TX_byte  (o_Eng_TX_byte),
        .o_Eng_TX_En    (o_Eng_TX_En),
        .i_Eng_TX_Ready (i_Eng_TX_Ready),
        .i_Eng_RX_byte  (i_Eng_RX_byte),
        .i_Eng_RX_En    (i_Eng_RX_En),
        .o_CS_n         (o_CS_n)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct { logic [7:0] b; int idx; bit last; } rx_exp_t;
    rx_exp_t    exp_rx_q[$];
    logic [7:0] exp_eng_q[$];
    rx_exp_t    mon_e;
    logic [7:0] mon_b;

    int cyc = 0, cs_fall_cyc = 0, rx_last_cyc = 0;
    int n_eng = 0, n_rx = 0, n_cs_fall = 0, n_eng_rx = 0;
    bit first_in_cs = 0, last_pending = 0, chk_lead = 1;
    bit cs_prev = 1, rdy_prev = 1;

    bit         eng_busy = 0, eng_stall = 0;
    int         eng_lat = 0, lat_lo = 1, lat_hi = 5;
    logic [7:0] eng_data = 8'h00;

    // Monitor first, then the loopback engine model, both on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (cs_prev && !o_CS_n) begin
            n_cs_fall++;
            cs_fall_cyc = cyc;
            first_in_cs = 1;
        end
        if (o_Eng_TX_En) begin
            n_eng++;
            check_eq("eng_ready", 32'(i_Eng_TX_Ready), 32'd1);
            check_eq("eng_cs_low", 32'(o_CS_n), 32'd0);
            check_eq("eng_expected", 32'(exp_eng_q.size() != 0), 32'd1);
            if (exp_eng_q.size() != 0) begin
                mon_b = exp_eng_q.pop_front();
                check_eq("eng_byte", 32'(o_Eng_TX_byte), 32'(mon_b));
            end
            if (first_in_cs && chk_lead) check_eq("lead_gap", cyc - cs_fall_cyc, LEAD);
            first_in_cs = 0;
        end
        if (o_RX_En) begin
            n_rx++;
            check_eq("rx_expected", 32'(exp_rx_q.size() != 0), 32'd1);
            if (exp_rx_q.size() != 0) begin
                mon_e = exp_rx_q.pop_front();
                check_eq("rx_byte", 32'(o_RX_byte), 32'(mon_e.b));
                check_eq("rx_count", 32'(o_RX_Count), mon_e.idx);
                check_eq("rx_cs_n", 32'(o_CS_n), 32'(mon_e.last));
                if (mon_e.last) begin
                    last_pending = 1;
                    rx_last_cyc  = cyc;
                end
            end
        end
        if (!rdy_prev && o_TX_Ready && last_pending) begin
            check_eq("inactive_gap", cyc - rx_last_cyc, INACT);
            last_pending = 0;
        end
        cs_prev  = o_CS_n;
        rdy_prev = o_TX_Ready;

        i_Eng_RX_En = 1'b0;
        if (o_Eng_TX_En && !eng_busy) begin
            eng_busy = 1;
            eng_data = o_Eng_TX_byte;
            eng_lat  = int'($urandom_range(lat_hi, lat_lo));
        end else if (eng_busy) begin
            if (eng_lat == 0) begin
                i_Eng_RX_En   = 1'b1;
                i_Eng_RX_byte = eng_data;
                eng_busy      = 0;
                n_eng_rx++;
            end else begin
                eng_lat--;
            end
        end
        i_Eng_TX_Ready = !eng_busy && !eng_stall;
    end

    task automatic wait_ready(input string tag);
        int k = 0;
        while (o_TX_Ready !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq(tag, 32'(o_TX_Ready), 32'd1);
    endtask

    // Present one byte for a single cycle and record what must come back.
    task automatic offer(input logic [7:0] b, input int n, input int idx);
        i_TX_Count = CW'(n);
        i_TX_byte  = b;
        i_TX_En    = 1'b1;
        exp_eng_q.push_back(b);
        exp_rx_q.push_back('{b: b, idx: idx, last: (idx == n)});
        @(posedge clk); #1;
        i_TX_En    = 1'b0;
        i_TX_byte  = 8'($urandom);
        i_TX_Count = CW'($urandom);
    endtask

    task automatic run_txn(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input bit inject, input bit stall);
        int f0 = n_cs_fall, e0 = n_eng, r0 = n_rx, k = 0;
        wait_ready("idle_ready");
        offer(b0, n, 1);
        if (stall) begin
            repeat (LEAD + 10) begin @(posedge clk); #1; end
            check_eq("stall_no_issue", n_eng - e0, 0);
            eng_stall = 0;
        end
        if (n == 2) begin
            wait_ready("wait_tx_ready");
            offer(b1, 2, 2);
            check_eq("next_issue", 32'(o_Eng_TX_En), 32'd1);
        end
        if (inject) begin
            while (n_eng - e0 < n && k < 200) begin @(posedge clk); #1; k++; end
            check_eq("wrx_not_ready", 32'(o_TX_Ready), 32'd0);
            i_TX_byte = 8'h33;
            i_TX_En   = 1'b1;
            @(posedge clk); #1;
            i_TX_En   = 1'b0;
            k = 0;
        end
        while ((n_rx - r0 < n || last_pending || o_TX_Ready !== 1'b1) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("txn_done", 32'(k < 300), 32'd1);
        check_eq("cs_frames", n_cs_fall - f0, 1);
        check_eq("eng_pulses", n_eng - e0, n);
        check_eq("rx_pulses", n_rx - r0, n);
    endtask

    task automatic bad_count(input int cnt);
        int f0 = n_cs_fall, bad = 0;
        wait_ready("bad_idle_ready");
        i_TX_Count = CW'(cnt);
        i_TX_byte  = 8'h77;
        i_TX_En    = 1'b1;
        @(posedge clk); #1;
        i_TX_En = 1'b0;
        repeat (10) begin
            if (o_TX_Ready !== 1'b1 || o_CS_n !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        check_eq("badcnt_idle_cycles", bad, 0);
        check_eq("badcnt_cs_frames", n_cs_fall - f0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        int e0, r0, q0, k;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs_n", 32'(o_CS_n), 32'd1);
        check_eq("rst_tx_ready", 32'(o_TX_Ready), 32'd1);
        check_eq("rst_eng_en", 32'(o_Eng_TX_En), 32'd0);
        check_eq("rst_rx_en", 32'(o_RX_En), 32'd0);
        check_eq("rst_rx_byte", 32'(o_RX_byte), 32'd0);
        check_eq("rst_eng_byte", 32'(o_Eng_TX_byte), 32'd0);
        check_eq("rst_rx_count", 32'(o_RX_Count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 8'hF1, 8'h00, 0, 0);
        run_txn(2, 8'hA5, 8'h5A, 0, 0);
        bad_count(0);
        bad_count(3);

        lat_lo = 6; lat_hi = 6;
        run_txn(1, 8'hC3, 8'h00, 1, 0);

        lat_lo = 1; lat_hi = 5;
        chk_lead  = 0;
        eng_stall = 1;
        run_txn(1, 8'h96, 8'h00, 0, 1);
        chk_lead  = 1;

        lat_lo = 8; lat_hi = 8;
        wait_ready("rst_txn_ready");
        e0 = n_eng;
        offer(8'h3C, 2, 1);
        k = 0;
        while (n_eng == e0 && k < 200) begin @(posedge clk); #1; k++; end
        check_eq("rst_txn_issued", n_eng - e0, 1);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("midrst_cs_n", 32'(o_CS_n), 32'd1);
        check_eq("midrst_tx_ready", 32'(o_TX_Ready), 32'd1);
        check_eq("midrst_rx_count", 32'(o_RX_Count), 32'd0);
        exp_rx_q.delete();
        exp_eng_q.delete();
        last_pending = 0;
        r0 = n_rx;
        q0 = n_eng_rx;
        repeat (15) begin @(posedge clk); #1; end
        check_eq("late_eng_rx_seen", n_eng_rx - q0, 1);
        check_eq("late_rx_ignored", n_rx - r0, 0);

        lat_lo = 1; lat_hi = 6;
        for (int t = 0; t < 24; t++) begin
            repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
            run_txn(int'($urandom_range(2, 1)), 8'($urandom), 8'($urandom), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
